// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control unit for the multicycle MIPS datapath. Sequences every
// instruction through fetch, decode, execute, memory and writeback. It drives
// the datapath enables and mux selects, and produces the 3-bit ALU opcode
// used by ALU_Control. Memory accesses use a ready handshake: FETCH, MEM_READ
// and MEM_WRITE hold until mem_ready_i is high.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   opcode_i         IR[31:26], looked at in DECODE and MEM_ADR only
//   mem_ready_i      memory finished the current read/write this cycle
//   pc_write_o       unconditional PC load
//   pc_write_cond_o  PC load qualified by ALU zero (beq)
//   i_or_d_o         memory address select: 0 = PC, 1 = ALUOut
//   mem_read_o       memory read request
//   mem_write_o      memory write request
//   ir_write_o       IR load
//   mem_to_reg_o     writeback data: 0 = ALUOut, 1 = MDR
//   reg_dst_o        destination register: 0 = rt, 1 = rd
//   reg_write_o      register file write
//   alu_src_a_o      0 = PC, 1 = A
//   alu_src_b_o      00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
//   pc_src_o         00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_op_o         100 = add, 001 = subtract, 111 = funct field, 000 = idle
//   illegal_op_o     sticky: an unsupported opcode was decoded
//   state_o          current state code, for debug
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic [2:0] alu_op_o,
  output logic       illegal_op_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12
  } state_e;

  localparam logic [2:0] ALU_IDLE  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    // Every single-cycle state, and the unused codes 13-15, return to FETCH.
    state_d         = S_FETCH;
    illegal_d       = illegal_q;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_src_o        = 2'b00;
    alu_op_o        = ALU_IDLE;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = ALU_ADD;
        // IR and PC+4 only commit in the cycle the instruction word arrives.
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        state_d     = mem_ready_i ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Branch target PC + (imm << 2) is computed speculatively here.
        alu_src_b_o = 2'b11;
        alu_op_o    = ALU_ADD;
        case (opcode_i)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end

      S_MEM_ADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = ALU_ADD;
        // IR is stable since FETCH, so re-reading the opcode is safe.
        if (opcode_i == OP_LW)      state_d = S_MEM_READ;
        else if (opcode_i == OP_SW) state_d = S_MEM_WRITE;
        else                        state_d = S_FETCH;
      end

      S_MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        state_d    = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      end

      S_MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end

      S_MEM_WRITE: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        state_d     = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      end

      S_EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
        state_d     = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end

      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_src_o        = 2'b01;
        pc_write_cond_o = 1'b1;
      end

      S_ADDI_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = ALU_ADD;
        state_d     = S_ADDI_WB;
      end

      S_ADDI_WB: reg_write_o = 1'b1;

      S_JUMP: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign illegal_op_o = illegal_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic [2:0] alu_op_o;
  logic       illegal_op_o;
  logic [3:0] state_o;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .pc_src_o(pc_src_o), .alu_op_o(alu_op_o),
    .illegal_op_o(illegal_op_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] src_b, pc_src;
    logic [2:0] alu_op;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  // One planned clock cycle: state the spec says we should be in, the
  // mem_ready_i value to apply, and the opcode presented on the IR.
  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic [5:0] op;
  } cyc_t;

  cyc_t plan[$];
  logic model_ill;
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OPC_R, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_J};
  endfunction

  // Expected outputs for a state, straight from the per-state output list.
  function automatic outs_t want_of(input logic [3:0] st, input logic mr, input logic ill);
    outs_t o;
    o = '0;
    o.state = st;
    o.illegal = ill;
    case (st)
      4'd1:  begin o.mem_read = 1; o.src_b = 2'b01; o.alu_op = 3'b100;
                   o.ir_write = mr; o.pc_write = mr; end
      4'd2:  begin o.src_b = 2'b11; o.alu_op = 3'b100; end
      4'd3:  begin o.alu_src_a = 1; o.src_b = 2'b10; o.alu_op = 3'b100; end
      4'd4:  begin o.mem_read = 1; o.i_or_d = 1; end
      4'd5:  begin o.mem_to_reg = 1; o.reg_write = 1; end
      4'd6:  begin o.mem_write = 1; o.i_or_d = 1; end
      4'd7:  begin o.alu_src_a = 1; o.alu_op = 3'b111; end
      4'd8:  begin o.reg_dst = 1; o.reg_write = 1; end
      4'd9:  begin o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_src = 2'b01;
                   o.pc_write_cond = 1; end
      4'd10: begin o.alu_src_a = 1; o.src_b = 2'b10; o.alu_op = 3'b100; end
      4'd11: o.reg_write = 1;
      4'd12: begin o.pc_src = 2'b10; o.pc_write = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic void push(input logic [3:0] st, input logic mr, input logic [5:0] op);
    cyc_t c;
    c.st = st; c.mr = mr; c.op = op;
    plan.push_back(c);
  endfunction

  // Append one whole instruction to the plan. During FETCH the IR holds
  // garbage (random opcode); ignored-ready states get a random ready bit.
  function automatic void plan_instr(input logic [5:0] op, input int fs, input int ms);
    for (int i = 0; i < fs; i++) push(4'd1, 1'b0, 6'($urandom));
    push(4'd1, 1'b1, 6'($urandom));
    push(4'd2, 1'($urandom), op);
    case (op)
      OPC_LW: begin
        push(4'd3, 1'($urandom), op);
        for (int i = 0; i < ms; i++) push(4'd4, 1'b0, op);
        push(4'd4, 1'b1, op);
        push(4'd5, 1'($urandom), op);
      end
      OPC_SW: begin
        push(4'd3, 1'($urandom), op);
        for (int i = 0; i < ms; i++) push(4'd6, 1'b0, op);
        push(4'd6, 1'b1, op);
      end
      OPC_R: begin
        push(4'd7, 1'($urandom), op);
        push(4'd8, 1'($urandom), op);
      end
      OPC_ADDI: begin
        push(4'd10, 1'($urandom), op);
        push(4'd11, 1'($urandom), op);
      end
      OPC_BEQ: push(4'd9, 1'($urandom), op);
      OPC_J:   push(4'd12, 1'($urandom), op);
      default: ;
    endcase
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o = {pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
         ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
         alu_src_b_o, pc_src_o, alu_op_o, illegal_op_o, state_o};
    return o;
  endfunction

  // Apply one planned cycle on the falling edge, sample 1ns later, and
  // advance the sticky-illegal model past a DECODE of a bad opcode.
  task automatic step(input cyc_t c, output outs_t got, output outs_t want);
    @(negedge clk);
    opcode_i    = c.op;
    mem_ready_i = c.mr;
    #1;
    got  = observed();
    want = want_of(c.st, c.mr, model_ill);
    if (c.st == 4'd2 && !is_legal(c.op)) model_ill = 1'b1;
  endtask

  task automatic test_reset();
    outs_t got, want;
    reset = 1'b0; opcode_i = OPC_LW; mem_ready_i = 1'b1;
    model_ill = 1'b0;
    #3;
    got = observed();
    n_cmp++;
    if (got !== outs_t'(0)) begin
      n_fail++; $display("FAIL reset_hold got=%h want=%h", got, outs_t'(0));
    end
    @(negedge clk);
    reset = 1'b1; mem_ready_i = 1'b0;
    #1;
    got = observed(); want = want_of(4'd0, 1'b0, 1'b0);
    n_cmp++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_release got=%h want=%h", got, want);
    end
  endtask

  task automatic test_rtype();
    outs_t got, want;
    plan_instr(OPC_R, 0, 0);
    while (plan.size() > 0) begin
      step(plan.pop_front(), got, want);
      n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL rtype st=%0d got=%h want=%h", want.state, got, want);
      end
    end
  endtask

  task automatic test_lw_stall();
    outs_t got, want;
    int ir_pulses = 0;
    int cycles = 0;
    plan_instr(OPC_LW, 2, 3);
    while (plan.size() > 0) begin
      step(plan.pop_front(), got, want);
      cycles++;
      ir_pulses += int'(got.ir_write);
      n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL lw_stall st=%0d got=%h want=%h", want.state, got, want);
      end
    end
    n_cmp++;
    if (ir_pulses != 1) begin
      n_fail++; $display("FAIL lw_ir_pulses got=%0d want=1", ir_pulses);
    end
    // Instruction must be back in FETCH right after its 10 cycles.
    step(cyc_t'({4'd1, 1'b0, 6'h3f}), got, want);
    n_cmp++;
    if (got !== want || cycles != 10) begin
      n_fail++; $display("FAIL lw_latency cycles=%0d st=%0d want 10 then st=1", cycles, got.state);
    end
  endtask

  task automatic test_sw_beq();
    outs_t got, want;
    plan_instr(OPC_SW, 0, 1);
    plan_instr(OPC_BEQ, 0, 0);
    while (plan.size() > 0) begin
      step(plan.pop_front(), got, want);
      n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL sw_beq st=%0d got=%h want=%h", want.state, got, want);
      end
    end
  endtask

  task automatic test_addi_j();
    outs_t got, want;
    plan_instr(OPC_ADDI, 1, 0);
    plan_instr(OPC_J, 0, 0);
    while (plan.size() > 0) begin
      step(plan.pop_front(), got, want);
      n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL addi_j st=%0d got=%h want=%h", want.state, got, want);
      end
    end
  endtask

  task automatic test_illegal();
    outs_t got, want;
    plan_instr(6'b111111, 0, 0);
    plan_instr(OPC_R, 0, 0);
    while (plan.size() > 0) begin
      step(plan.pop_front(), got, want);
      n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL illegal st=%0d got=%h want=%h", want.state, got, want);
      end
    end
    n_cmp++;
    if (illegal_op_o !== 1'b1) begin
      n_fail++; $display("FAIL illegal_sticky got=%b want=1", illegal_op_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    outs_t got, want;
    push(4'd1, 1'b1, OPC_LW);
    push(4'd2, 1'b1, OPC_LW);
    push(4'd3, 1'b0, OPC_LW);
    push(4'd4, 1'b0, OPC_LW);
    push(4'd4, 1'b0, OPC_LW);
    while (plan.size() > 0) begin
      step(plan.pop_front(), got, want);
      n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL mid_stall_pre st=%0d got=%h want=%h", want.state, got, want);
      end
    end
    #1;
    mem_ready_i = 1'b1;
    reset = 1'b0;
    #1;
    model_ill = 1'b0;
    got = observed();
    n_cmp++;
    if (got !== outs_t'(0)) begin
      n_fail++; $display("FAIL mid_stall_async got=%h want=%h", got, outs_t'(0));
    end
    @(negedge clk);
    reset = 1'b1; mem_ready_i = 1'b1;
    #1;
    got = observed(); want = want_of(4'd0, 1'b1, 1'b0);
    n_cmp++;
    if (got !== want) begin
      n_fail++; $display("FAIL mid_stall_rst_state got=%h want=%h", got, want);
    end
    plan_instr(OPC_R, 0, 0);
    while (plan.size() > 0) begin
      step(plan.pop_front(), got, want);
      n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL mid_stall_post st=%0d got=%h want=%h", want.state, got, want);
      end
    end
  endtask

  task automatic test_random();
    outs_t got, want;
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{OPC_R, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_J};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      plan_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      while (plan.size() > 0) begin
        step(plan.pop_front(), got, want);
        n_cmp++;
        if (got !== want) begin
          n_fail++; $display("FAIL random op=%b st=%0d got=%h want=%h", op, want.state, got, want);
        end
        n_cmp++;
        if ((got.mem_read && got.mem_write) || (got.pc_write && got.pc_write_cond)) begin
          n_fail++; $display("FAIL exclusive got=%h want no rd&wr, no pcw&pcwc", got);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_beq();
    test_addi_j();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
